// File: rtl/sysid_reader_pkg.sv
// Shared types and constants for the system-ID reader: FSM state encoding,
// sysid word addresses, default expected values and stall-counter width.
package sysid_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_ID = 3'd1,
    ST_RD_TS = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic ADDR_ID        = 1'b0;
  localparam logic ADDR_TIMESTAMP = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'd0;
  localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1434373291;

  // Wide enough for the largest allowed TIMEOUT_CYCLES (65535).
  localparam int CNT_W = 16;

endpackage

// File: rtl/sysid_timeout_counter.sv
// Clear/enable stall counter. hit flags an enabled cycle on which the count
// would reach LIMIT, so the caller can act on that same edge.
module sysid_timeout_counter
  import sysid_reader_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             hit
);

  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(LIMIT - 1);

  assign hit = enable && (count == LIMIT_M1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sysid_reader.sv
// Avalon-MM master that reads sysid words 0 (ID) and 1 (timestamp) and compares
// them with build-time values. Define SYSID_READER_AUTOSTART_EN to self-start after reset.
module sysid_reader
  import sysid_reader_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
  parameter int          TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value
);

  // Avalon read handshake: avm_read/avm_address are held until a cycle with
  // avm_waitrequest low; avm_readdata is taken on exactly that cycle.
  state_t           state;
  logic             start_int;
  logic             start_accept;
  logic             cnt_clear;
  logic             cnt_enable;
  logic             cnt_hit;
  logic [CNT_W-1:0] cnt_value;

`ifdef SYSID_READER_AUTOSTART_EN
  logic auto_pending;

  // One-shot: pending through reset, fires on the first edge after release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      auto_pending <= 1'b1;
    end else begin
      auto_pending <= 1'b0;
    end
  end

  assign start_int = start || auto_pending;
`else
  assign start_int = start;
`endif

  assign start_accept = start_int && ((state == ST_IDLE) || (state == ST_DONE));
  assign cnt_enable   = ((state == ST_RD_ID) || (state == ST_RD_TS)) && avm_waitrequest;
  assign cnt_clear    = start_accept || ((state == ST_RD_ID) && !avm_waitrequest);

  sysid_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .count  (cnt_value),
    .hit    (cnt_hit)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      avm_address     <= ADDR_ID;
      avm_read        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      timeout         <= 1'b0;
      id_value        <= '0;
      timestamp_value <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_accept) begin
            state           <= ST_RD_ID;
            avm_address     <= ADDR_ID;
            avm_read        <= 1'b1;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            timeout         <= 1'b0;
            id_value        <= '0;
            timestamp_value <= '0;
          end
        end
        ST_RD_ID, ST_RD_TS: begin
          // Completion takes priority over a stall that would hit the limit.
          if (!avm_waitrequest) begin
            if (state == ST_RD_ID) begin
              id_value    <= avm_readdata;
              avm_address <= ADDR_TIMESTAMP;
              state       <= ST_RD_TS;
            end else begin
              timestamp_value <= avm_readdata;
              avm_read        <= 1'b0;
              state           <= ST_CHECK;
            end
          end else if (cnt_hit) begin
            avm_read <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            pass     <= 1'b0;
            timeout  <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_CHECK: begin
          pass  <= (id_value == EXPECTED_ID) && (timestamp_value == EXPECTED_TIMESTAMP);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_reader.sv
// Directed bench for sysid_reader with a behavioural sysid slave and a read-address
// scoreboard; honours SYSID_READER_AUTOSTART_EN when the design is built with it.
module tb_sysid_reader;

  localparam int          TMO   = 8;
  localparam logic [31:0] TS_OK = 32'd1434373291;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [31:0] id_value;
  logic [31:0] timestamp_value;

  int compared   = 0;
  int mismatched = 0;

  logic [1:0]  exp_q[$];
  logic [31:0] id_data    = 32'd0;
  logic [31:0] ts_data    = TS_OK;
  int          stall_cfg  = 0;
  int          stall_left = 0;
  logic        stuck      = 1'b0;
  logic        stab_en    = 1'b0;
  logic        prev_stall = 1'b0;
  logic        prev_addr  = 1'b0;

  sysid_reader #(
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .timeout         (timeout),
    .id_value        (id_value),
    .timestamp_value (timestamp_value)
  );

  always #5 clock = ~clock;

  // Sysid slave: stalls stall_cfg cycles at the start of every read.
  assign avm_waitrequest = stuck || (stall_left != 0);
  assign avm_readdata    = avm_address ? ts_data : id_data;

  always @(posedge clock) begin
    if (!avm_read || stall_left == 0) stall_left <= stall_cfg;
    else stall_left <= stall_left - 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: read completions against the expected-address queue, and
  // address/strobe stability across stalled cycles.
  always @(negedge clock) begin
    logic [1:0] exp_addr;
    if (stab_en && prev_stall) begin
      check("stall_read", {31'd0, avm_read}, 32'd1);
      check("stall_addr", {31'd0, avm_address}, {31'd0, prev_addr});
    end
    prev_stall = avm_read && avm_waitrequest;
    prev_addr  = avm_address;
    if (!reset && avm_read && !avm_waitrequest) begin
      exp_addr = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b10;
      check("read_addr", {31'd0, avm_address}, {30'd0, exp_addr});
    end
  end

  task automatic run(input string tag, input bit do_start, input int n_reads, input int extra_at,
                     input int exp_lat, input logic exp_pass, input logic exp_to,
                     input logic [31:0] exp_id, input logic [31:0] exp_ts);
    int lat;
    for (int i = 0; i < n_reads; i++) exp_q.push_back(2'(i));
    start = do_start;
    @(negedge clock);
    lat = 1;
    while (!done && lat < 200) begin
      start = (lat == extra_at);
      @(negedge clock);
      lat++;
    end
    start = 1'b0;
    check({tag, "_latency"}, lat - 1, exp_lat);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_pass"}, {31'd0, pass}, {31'd0, exp_pass});
    check({tag, "_timeout"}, {31'd0, timeout}, {31'd0, exp_to});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_read"}, {31'd0, avm_read}, 32'd0);
    check({tag, "_id"}, id_value, exp_id);
    check({tag, "_ts"}, timestamp_value, exp_ts);
    check({tag, "_reads_left"}, exp_q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_read"}, {31'd0, avm_read}, 32'd0);
    check({tag, "_addr"}, {31'd0, avm_address}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_pass"}, {31'd0, pass}, 32'd0);
    check({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
    check({tag, "_id"}, id_value, 32'd0);
    check({tag, "_ts"}, timestamp_value, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clock);
    check_zero("reset");

    reset = 1'b0;
`ifdef SYSID_READER_AUTOSTART_EN
    run("autostart", 1'b0, 2, 0, 3, 1'b1, 1'b0, 32'd0, TS_OK);
`else
    repeat (4) @(negedge clock);
    check_zero("idle_after_reset");
`endif

    run("basic", 1'b1, 2, 0, 3, 1'b1, 1'b0, 32'd0, TS_OK);

    id_data = 32'd1;
    run("bad_id", 1'b1, 2, 0, 3, 1'b0, 1'b0, 32'd1, TS_OK);
    id_data = 32'd0;

    stall_cfg = 5;
    stab_en   = 1'b1;
    @(negedge clock);
    run("stall5", 1'b1, 2, 0, 13, 1'b1, 1'b0, 32'd0, TS_OK);
    stab_en   = 1'b0;
    stall_cfg = 0;

    stuck = 1'b1;
    run("timeout", 1'b1, 0, 0, TMO, 1'b0, 1'b1, 32'd0, 32'd0);
    stuck = 1'b0;
    @(negedge clock);

    stall_cfg = TMO - 1;
    @(negedge clock);
    run("edge", 1'b1, 2, 0, 3 + 2 * (TMO - 1), 1'b1, 1'b0, 32'd0, TS_OK);

    // Reset while the timestamp read is stalled.
    stall_cfg = 5;
    @(negedge clock);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    check("midrst_busy_before", {31'd0, busy}, 32'd1);
    check("midrst_addr_before", {31'd0, avm_address}, 32'd1);
    reset = 1'b1;
    #1;
    check_zero("midrst");
    check("midrst_reads_left", exp_q.size(), 1);
    exp_q.delete();
    stall_cfg = 0;
    @(negedge clock);
    reset = 1'b0;
`ifdef SYSID_READER_AUTOSTART_EN
    run("after_rst", 1'b0, 2, 0, 3, 1'b1, 1'b0, 32'd0, TS_OK);
`else
    @(negedge clock);
    run("after_rst", 1'b1, 2, 0, 3, 1'b1, 1'b0, 32'd0, TS_OK);
`endif

    stall_cfg = 2;
    @(negedge clock);
    run("busy_start", 1'b1, 2, 2, 7, 1'b1, 1'b0, 32'd0, TS_OK);
    stall_cfg = 0;
    repeat (4) @(negedge clock);
    check("busy_start_idle_busy", {31'd0, busy}, 32'd0);
    check("busy_start_idle_done", {31'd0, done}, 32'd1);
    check("busy_start_idle_reads", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sysid_reader.md
# sysid_reader

Avalon-MM master that reads the Qsys system-ID slave and checks it against build-time expected values. After `start` (or automatically after reset), it reads address 0 (system ID) and address 1 (timestamp), then reports pass/fail or timeout. It sits beside the sysid slave on the same interconnect and gates software boot when the loaded image does not match the FPGA build.

## Interface
- `EXPECTED_ID`, default 0: value required at sysid address 0.
- `EXPECTED_TIMESTAMP`, default 1434373291: value required at sysid address 1.
- `TIMEOUT_CYCLES`, default 255: maximum waitrequest-stalled cycles per read. Range 1..65535.

Ports:
- `clock`  in  1: single clock for all logic.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: single-cycle request to run a check.
- `avm_address`  out  1: sysid word address (0 = ID, 1 = timestamp).
- `avm_read`  out  1: read strobe, held until accepted.
- `avm_waitrequest`  in  1: slave stall. A read completes on a cycle with `avm_read` high and `avm_waitrequest` low.
- `avm_readdata`  in  32: read data, valid on the completing cycle.
- `busy`  out  1: check in progress.
- `done`  out  1: result valid. Sticky until the next accepted start or reset.
- `pass`  out  1: both values matched. Valid only while `done` is high.
- `timeout`  out  1: a read exceeded `TIMEOUT_CYCLES`. Valid only while `done` is high.
- `id_value`  out  32: captured address-0 data.
- `timestamp_value`  out  32: captured address-1 data.

## Operation
- States: IDLE, RD_ID, RD_TS, CHECK, DONE.
- IDLE or DONE, `start`=1 → RD_ID. Entering RD_ID clears `done`, `pass`, `timeout`, the captured values and the stall counter.
- `start` in RD_ID, RD_TS or CHECK is ignored. No queuing.
- RD_ID: `avm_address`=0, `avm_read`=1.
  - On completion: capture `avm_readdata` into `id_value`, clear the stall counter, go to RD_TS.
- RD_TS: `avm_address`=1, `avm_read`=1.
  - On completion: capture `timestamp_value`, go to CHECK.
- Stall counter: increments each RD_ID/RD_TS cycle in which `avm_waitrequest`=1.
  - When the counter reaches `TIMEOUT_CYCLES` on a stalled cycle: go to DONE with `timeout`=1, `pass`=0.
  - `avm_read` drops on that same edge. The partially captured value stays as-is.
  - Completion on the same cycle the counter would hit the limit: completion wins.
- CHECK: `pass` ← (`id_value`==`EXPECTED_ID`) && (`timestamp_value`==`EXPECTED_TIMESTAMP`). Go to DONE.
- DONE: `done`=1. Hold all results until the next `start`.
- `busy`=1 in RD_ID, RD_TS and CHECK.
- `avm_address` and `avm_read` are registered and stable for the whole of a stalled read.
- Reset (asynchronous, including mid-read) values: state IDLE, `avm_read`=0, `avm_address`=0, `busy`=0, `done`=0, `pass`=0, `timeout`=0, `id_value`=0, `timestamp_value`=0, counter 0.

## Timing
- Start sampled at edge E0. The ID read is presented in the following cycle.
- Zero-wait slave: ID captured at E1, timestamp at E2, CHECK at E3. `done`/`pass` are high after E3.
- Start-to-done latency is 3 cycles plus the total stall cycles.
- Consecutive reads have no idle cycle between them.
- Timeout case: with the slave stalled from the first RD_ID cycle, `done`=1 and `timeout`=1 appear `TIMEOUT_CYCLES` cycles after RD_ID is entered.

## Configuration
- `SYSID_READER_AUTOSTART_EN` defined: an internal one-shot generates a start on the first clock edge after `reset` deasserts. External `start` still works afterwards.
- Macro undefined: checks run only on `start`. After reset the block stays in IDLE with `done`=0.

## Structure
- Package `sysid_reader_pkg` holds:
  - the state enum;
  - the address constants (ID=0, TIMESTAMP=1);
  - default expected-value constants;
  - the counter width, derived as 16 bits.
- One sub-module, `sysid_timeout_counter`: a clear/enable counter that flags when it reaches `TIMEOUT_CYCLES`.
- The FSM and capture registers stay in the top module.

## Test plan
- Zero-wait slave returning 0 / 1434373291, start pulse → reads at addresses 0 then 1 on consecutive cycles; `done`=1, `pass`=1, `timeout`=0, three cycles after start.
- Slave returns 0x00000001 at address 0 → `done`=1, `pass`=0, `id_value`=1.
- Waitrequest held 5 cycles on each read with `TIMEOUT_CYCLES`=255 → address and read stay stable while stalled; `pass`=1 after 13 cycles.
- Waitrequest stuck high with `TIMEOUT_CYCLES`=8 → `avm_read` drops, `timeout`=1, `pass`=0 after 8 stalled cycles; completion in the 8th stalled cycle instead gives a normal pass.
- Assert `reset` while RD_TS is stalled → all outputs zero immediately; a new start afterwards gives `pass`=1.
- `start` pulsed while busy → ignored with no extra reads. Built with `SYSID_READER_AUTOSTART_EN` → a check runs with no `start` after reset release.
